inst_fetch_unit: RTL

- Instruction fetch stage directly upstream of the single-cycle datapath.
- Issues in-order read requests to instruction memory over a valid/ready request channel and accepts in-order responses of any latency.
- Buffers fetched instructions in a DEPTH-entry queue.
- Presents each instruction, its PC and its pre-sliced register/immediate fields to the decode/datapath side with a valid/ready handshake.
- Supports a branch/jump redirect that flushes all in-flight and buffered instructions.

---
 rtl/inst_fetch_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage feeding the single-cycle datapath. Issues in-order
// fetch requests to instruction memory, accepts in-order responses of any
// latency, buffers them in a DEPTH-entry queue and presents the oldest
// instruction (with its PC and pre-sliced register/immediate fields) to the
// decode side over a valid/ready handshake. A redirect flushes everything in
// flight and restarts fetch at a new PC. Responses that belong to flushed
// requests are counted in dropCount and silently discarded when they return.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   imemReqValid/Ready/Addr        fetch request channel (Addr = fetch PC)
//   imemRespValid/Data             in-order fetch responses
//   instValid/Ready                head-of-queue handshake to the consumer
//   instData, instPC               head instruction and its PC (0 when idle)
//   srcRegister1/2, desRegister    rs1 = [19:15], rs2 = [24:20], rd = [11:7]
//   imm                            instData[31:7]
//   redirect, redirectPC           flush and restart fetch at redirectPC & ~3
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imemReqValid,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemRespValid,
  input  logic [31:0]     imemRespData,
  output logic            instValid,
  input  logic            instReady,
  output logic [31:0]     instData,
  output logic [XLEN-1:0] instPC,
  output logic [4:0]      srcRegister1,
  output logic [4:0]      srcRegister2,
  output logic [4:0]      desRegister,
  output logic [24:0]     imm,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPC
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DROP_W = $clog2(DEPTH + 1) + 1;

  // Control state (reset)
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DEPTH-1:0]  filled_q, filled_d;

  // Queue payload (not reset; qualified by filled_q / count_q)
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [31:0]       data_q [DEPTH];

  logic alloc;
  logic fill;
  logic drop_resp;
  logic resp_taken;
  logic pop;
  logic inst_valid;
  logic req_valid;

  // The two low PC bits of a redirect target are architecturally ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirectPC[1:0];

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // The full check uses the registered count: a same-cycle pop never frees a
  // slot for a same-cycle request.
  assign req_valid  = !rst && !redirect && (count_q < CNT_W'(DEPTH));
  assign alloc      = req_valid && imemReqReady;

  // Responses for flushed requests are always consumed first (in order).
  assign drop_resp  = imemRespValid && (drop_q != '0);
  // A response with nothing pending and nothing to drop is ignored.
  assign fill       = imemRespValid && (drop_q == '0) && (pend_q != '0) && !redirect;
  // Any legal response present this cycle; used to account for the one that
  // a redirect swallows in its own cycle.
  assign resp_taken = imemRespValid && ((drop_q != '0) || (pend_q != '0));

  // No bypass: an entry filled this cycle is only visible next cycle.
  assign inst_valid = !redirect && (count_q != '0) && filled_q[head_q];
  assign pop        = inst_valid && instReady;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    filled_d   = filled_q;

    if (redirect) begin
      fetch_pc_d = {redirectPC[XLEN-1:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      pend_d     = '0;
      filled_d   = '0;
      // Every still-pending request will return a response that must be
      // discarded; the response arriving right now is already gone.
      drop_d     = drop_q + DROP_W'(pend_q) - DROP_W'(resp_taken);
    end else begin
      if (alloc) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_W'(1);
        fetch_pc_d       = fetch_pc_q + XLEN'(4);
      end
      if (fill) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PTR_W'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      if (drop_resp) begin
        drop_d = drop_q - DROP_W'(1);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      pend_d  = pend_q + CNT_W'(alloc) - CNT_W'(fill);
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
    end
  end

  // -------------------------------------------------------------------------
  // Queue payload registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[tail_q] <= fetch_pc_q;
    end
    if (fill) begin
      data_q[fill_q] <= imemRespData;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imemReqValid = req_valid;
  assign imemReqAddr  = fetch_pc_q;
  assign instValid    = inst_valid;
  assign instData     = inst_valid ? data_q[head_q] : 32'h0;
  assign instPC       = inst_valid ? pc_q[head_q]   : '0;
  assign srcRegister1 = instData[19:15];
  assign srcRegister2 = instData[24:20];
  assign desRegister  = instData[11:7];
  assign imm          = instData[31:7];

endmodule
